// File: rtl/tank_pkg.sv
// Shared types for the obstacle map generator: obstacle record, generator
// FSM states and the strict rectangle-intersection test.
package tank_pkg;

    localparam int MAP_W_DEF = 640;
    localparam int MAP_H_DEF = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] w;
        logic [5:0] h;
    } obstacle_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SX,
        S_SY,
        S_SW,
        S_SH,
        S_CHK,
        S_WR,
        S_FIN
    } gen_state_e;

    // Edges are widened to 11 bits so x+w never wraps; touching edges do not count.
    function automatic logic rects_overlap(input obstacle_t a, input obstacle_t b);
        logic [10:0] ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
        ax0 = {1'b0, a.x};
        ay0 = {1'b0, a.y};
        bx0 = {1'b0, b.x};
        by0 = {1'b0, b.y};
        ax1 = ax0 + {5'd0, a.w};
        ay1 = ay0 + {5'd0, a.h};
        bx1 = bx0 + {5'd0, b.w};
        by1 = by0 + {5'd0, b.h};
        return (ax0 < bx1) && (bx0 < ax1) && (ay0 < by1) && (by0 < ay1);
    endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational strict-intersection test between two obstacle rectangles.
module rect_overlap
    import tank_pkg::*;
(
    input  obstacle_t a_i,
    input  obstacle_t b_i,
    output logic      hit_o
);

    assign hit_o = rects_overlap(a_i, b_i);

endmodule

// File: rtl/obstacle_map_gen.sv
// Builds up to NUM_OBS random obstacles inside the map and clear of both
// spawn squares; the table is readable combinationally at any time.
module obstacle_map_gen
    import tank_pkg::*;
#(
    parameter int NUM_OBS    = 8,
    parameter int MAP_W      = MAP_W_DEF,
    parameter int MAP_H      = MAP_H_DEF,
    parameter int MIN_SIZE   = 16,
    parameter int MAX_TRIES  = 15,
    parameter int SPAWN0_X   = 32,
    parameter int SPAWN0_Y   = 32,
    parameter int SPAWN1_X   = 576,
    parameter int SPAWN1_Y   = 416,
    parameter int SPAWN_SIZE = 32
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    input  logic [9:0]                 rnd,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_OBS):0]   obs_count,
    input  logic [$clog2(NUM_OBS)-1:0] rd_idx,
    output logic                       rd_valid,
    output logic [9:0]                 rd_x,
    output logic [9:0]                 rd_y,
    output logic [5:0]                 rd_w,
    output logic [5:0]                 rd_h
);

    localparam int IDXW = $clog2(NUM_OBS);
    localparam int CW   = IDXW + 1;
    localparam int TW   = $clog2(MAX_TRIES + 1);

    localparam obstacle_t SPAWN0 = '{x: 10'(SPAWN0_X), y: 10'(SPAWN0_Y),
                                     w: 6'(SPAWN_SIZE), h: 6'(SPAWN_SIZE)};
    localparam obstacle_t SPAWN1 = '{x: 10'(SPAWN1_X), y: 10'(SPAWN1_Y),
                                     w: 6'(SPAWN_SIZE), h: 6'(SPAWN_SIZE)};

    gen_state_e                 state_q, state_d;
    logic [IDXW-1:0]            slot_q, slot_d;
    logic [TW-1:0]              tries_q, tries_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    obstacle_t                  cur_q, cur_d;
    obstacle_t [NUM_OBS-1:0]    tab_q;
    logic [NUM_OBS-1:0]         valid_q;

    logic wr_en, clr_valid, reject, last_slot, fits, hit0, hit1;

    rect_overlap u_ov_spawn0 (.a_i(cur_q), .b_i(SPAWN0), .hit_o(hit0));
    rect_overlap u_ov_spawn1 (.a_i(cur_q), .b_i(SPAWN1), .hit_o(hit1));

    assign last_slot = (slot_q == IDXW'(NUM_OBS - 1));
    assign fits = (({1'b0, cur_q.x} + {5'd0, cur_q.w}) <= 11'(MAP_W)) &&
                  (({1'b0, cur_q.y} + {5'd0, cur_q.h}) <= 11'(MAP_H));

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        tries_d   = tries_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cur_d     = cur_q;
        wr_en     = 1'b0;
        clr_valid = 1'b0;
        reject    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr_valid = 1'b1;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    slot_d    = '0;
                    tries_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SX;
                end
            end
            S_SX: begin
                if ({1'b0, rnd} < 11'(MAP_W)) begin
                    cur_d.x = rnd;
                    state_d = S_SY;
                end else begin
                    reject = 1'b1;
                end
            end
            S_SY: begin
                if ({1'b0, rnd} < 11'(MAP_H)) begin
                    cur_d.y = rnd;
                    state_d = S_SW;
                end else begin
                    reject = 1'b1;
                end
            end
            S_SW: begin
                cur_d.w = 6'(MIN_SIZE) + {1'b0, rnd[4:0]};
                state_d = S_SH;
            end
            S_SH: begin
                cur_d.h = 6'(MIN_SIZE) + {1'b0, rnd[4:0]};
                state_d = S_CHK;
            end
            S_CHK: begin
                if (fits && !hit0 && !hit1) state_d = S_WR;
                else                        reject  = 1'b1;
            end
            S_WR: begin
                wr_en   = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                tries_d = '0;
                if (last_slot) begin
                    state_d = S_FIN;
                end else begin
                    slot_d  = slot_q + IDXW'(1);
                    state_d = S_SX;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Out of tries: abandon this slot (left invalid) and move on.
        if (reject) begin
            state_d = S_SX;
            if (tries_q == TW'(MAX_TRIES)) begin
                tries_d = '0;
                if (last_slot) state_d = S_FIN;
                else           slot_d  = slot_q + IDXW'(1);
            end else begin
                tries_d = tries_q + TW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            tries_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            tries_q <= tries_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cur_q   <= cur_d;
        end
    end

    // A new run clears only the valid bits; stale fields stay but are masked.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tab_q   <= '0;
            valid_q <= '0;
        end else begin
            if (clr_valid) valid_q <= '0;
            if (wr_en) begin
                tab_q[slot_q]   <= cur_q;
                valid_q[slot_q] <= 1'b1;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign obs_count = cnt_q;
    assign rd_valid  = valid_q[rd_idx];
    assign rd_x      = tab_q[rd_idx].x;
    assign rd_y      = tab_q[rd_idx].y;
    assign rd_w      = tab_q[rd_idx].w;
    assign rd_h      = tab_q[rd_idx].h;

endmodule

// File: tb/tb_obstacle_map_gen.sv
// Randomised and directed bench for obstacle_map_gen against a slot-by-slot
// reference model that consumes the random stream one value per cycle.
module tb_obstacle_map_gen;

    localparam int NUM_OBS   = 8;
    localparam int MAP_W     = 640;
    localparam int MAP_H     = 480;
    localparam int MIN_SIZE  = 16;
    localparam int MAX_TRIES = 15;
    localparam int SLEN      = 800;

    logic       Clk = 1'b0;
    logic       Reset_n, start, busy, done, rd_valid;
    logic [9:0] rnd, rd_x, rd_y;
    logic [5:0] rd_w, rd_h;
    logic [3:0] obs_count;
    logic [2:0] rd_idx;

    int stim [SLEN];
    int mx [NUM_OBS], my [NUM_OBS], mw [NUM_OBS], mh [NUM_OBS];
    bit mv [NUM_OBS];
    int mcnt;
    int n_chk = 0;
    int n_pass = 0;

    obstacle_map_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .rnd(rnd),
        .busy(busy), .done(done), .obs_count(obs_count), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w), .rd_h(rd_h)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic bit hits(input int x, input int y, input int w, input int h,
                                input int bx, input int by, input int bs);
        return (x < bx + bs) && (bx < x + w) && (y < by + bs) && (by < y + h);
    endfunction

    // Walk the stream slot by slot; returns cycles consumed after the start edge.
    task automatic model_run(output int cyc);
        int p, tries, x, y, w, h;
        bit fin, ok;
        p = 0;
        mcnt = 0;
        for (int i = 0; i < NUM_OBS; i++) mv[i] = 1'b0;
        for (int s = 0; s < NUM_OBS; s++) begin
            tries = 0;
            fin = 1'b0;
            while (!fin) begin
                ok = 1'b0;
                x = stim[p]; p++;
                if (x < MAP_W) begin
                    y = stim[p]; p++;
                    if (y < MAP_H) begin
                        w = MIN_SIZE + (stim[p] % 32); p++;
                        h = MIN_SIZE + (stim[p] % 32); p++;
                        p++;
                        ok = (x + w <= MAP_W) && (y + h <= MAP_H) &&
                             !hits(x, y, w, h, 32, 32, 32) &&
                             !hits(x, y, w, h, 576, 416, 32);
                    end
                end
                if (ok) begin
                    p++;
                    mx[s] = x; my[s] = y; mw[s] = w; mh[s] = h;
                    mv[s] = 1'b1;
                    mcnt++;
                    fin = 1'b1;
                end else if (tries == MAX_TRIES) begin
                    fin = 1'b1;
                end else begin
                    tries++;
                end
            end
        end
        cyc = p;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < SLEN; i++)
            stim[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                                  : int'($urandom_range(0, 479));
    endtask

    task automatic put(input int pos, input int a, input int b, input int c, input int d);
        stim[pos] = a; stim[pos+1] = b; stim[pos+2] = c; stim[pos+3] = d;
        stim[pos+4] = 0; stim[pos+5] = 0;
    endtask

    task automatic put_nom(input int from, input int nslots);
        for (int s = 0; s < nslots; s++) put(from + 6*s, 100, 50, 4, 8);
    endtask

    task automatic check_table(input string nm);
        for (int i = 0; i < NUM_OBS; i++) begin
            rd_idx = 3'(i);
            #1;
            chk($sformatf("%s_v%0d", nm, i), int'(rd_valid), int'(mv[i]));
            if (mv[i]) begin
                chk($sformatf("%s_x%0d", nm, i), int'(rd_x), mx[i]);
                chk($sformatf("%s_y%0d", nm, i), int'(rd_y), my[i]);
                chk($sformatf("%s_w%0d", nm, i), int'(rd_w), mw[i]);
                chk($sformatf("%s_h%0d", nm, i), int'(rd_h), mh[i]);
            end
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_cnt"}, int'(obs_count), 0);
        for (int i = 0; i < NUM_OBS; i++) begin
            rd_idx = 3'(i);
            #1;
            chk($sformatf("%s_v%0d", nm, i), int'(rd_valid), 0);
        end
    endtask

    task automatic run_gen(input string nm, input bit poke, input int exp_lat);
        int p, lat;
        bit seen;
        model_run(p);
        @(negedge Clk);
        start = 1'b1;
        rnd = 10'($urandom_range(0, 1023));
        @(posedge Clk);
        seen = 1'b0;
        lat = -1;
        for (int k = 0; k < SLEN && !seen; k++) begin
            @(negedge Clk);
            start = poke && (k == 9);
            rnd = 10'(stim[k]);
            if (k == 0) chk({nm, "_busy_run"}, int'(busy), 1);
            if (done) begin
                seen = 1'b1;
                lat = k;
            end
        end
        start = 1'b0;
        chk({nm, "_lat"}, lat, p + 1);
        if (exp_lat >= 0) chk({nm, "_lat_abs"}, lat, exp_lat);
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_busy_end"}, int'(busy), 0);
        chk({nm, "_cnt"}, int'(obs_count), mcnt);
        check_table(nm);
    endtask

    initial begin
        Reset_n = 1'b0;
        start = 1'b0;
        rnd = '0;
        rd_idx = '0;
        #12;
        check_reset("rst");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Nominal: every slot accepted first time, done 49 edges after the start edge.
        fill_rand(); put_nom(0, 8);
        run_gen("nom", 1'b0, 49);
        chk("nom_cnt8", int'(obs_count), 8);

        // Out-of-range x costs one extra cycle and is never stored.
        fill_rand(); stim[0] = 700; put_nom(1, 8);
        run_gen("range", 1'b0, 50);

        // Right edge exactly on the map boundary accepted; one pixel past rejected.
        fill_rand(); put(0, 620, 300, 4, 0); put(6, 621, 300, 4, 0); put_nom(11, 7);
        run_gen("bound", 1'b0, -1);
        rd_idx = 3'd0; #1;
        chk("bound_x0", int'(rd_x), 620);
        rd_idx = 3'd1; #1;
        chk("bound_x1", int'(rd_x), 100);

        // Spawn overlap rejected; merely touching the spawn edge accepted.
        fill_rand(); put(0, 40, 40, 0, 0); put(5, 64, 32, 0, 0); put_nom(11, 7);
        run_gen("keep", 1'b0, -1);
        rd_idx = 3'd0; #1;
        chk("keep_x0", int'(rd_x), 64);

        // Exhaustion: every slot skipped after 16 rejects.
        for (int i = 0; i < SLEN; i++) stim[i] = 1023;
        run_gen("exh", 1'b0, 129);
        chk("exh_cnt0", int'(obs_count), 0);

        // Start pulsed mid-run must be ignored.
        fill_rand(); put_nom(0, 8);
        run_gen("poke", 1'b1, 49);

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            run_gen($sformatf("rnd%0d", r), r[0], -1);
        end

        // Asynchronous reset mid-run wipes partial results immediately.
        fill_rand(); put_nom(0, 8);
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            start = 1'b0;
            rnd = 10'(stim[k]);
        end
        rd_idx = 3'd0; #1;
        chk("mid_v0_pre", int'(rd_valid), 1);
        #1;
        Reset_n = 1'b0;
        #1;
        check_reset("mid");
        for (int i = 0; i < NUM_OBS; i++) mv[i] = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;

        fill_rand();
        run_gen("post", 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/obstacle_map_gen.md
Name: obstacle_map_gen

Overview:
Consumes the free-running 10-bit pseudo-random word during the map-generation state of the game FSM. Turns successive random samples into up to NUM_OBS axis-aligned obstacle rectangles that lie inside the map and clear of both tank spawn zones. Stores them in an internal table that the renderer and collision logic read through a combinational port. One run per start pulse; done tells the game FSM to leave map generation.

Parameters:
NUM_OBS, 8, obstacle table depth (power of 2, >=2)
MAP_W, 640, map width in pixels
MAP_H, 480, map height in pixels
MIN_SIZE, 16, minimum obstacle edge; edge = MIN_SIZE + rnd[4:0]
MAX_TRIES, 15, rejections allowed per slot before the slot is skipped
SPAWN0_X, 32, tank 0 keep-out origin x
SPAWN0_Y, 32, tank 0 keep-out origin y
SPAWN1_X, 576, tank 1 keep-out origin x
SPAWN1_Y, 416, tank 1 keep-out origin y
SPAWN_SIZE, 32, keep-out square edge

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to (re)generate the map
rnd  in  10  random word, new value every cycle
busy  out  1  generation in progress
done  out  1  level; a run has completed
obs_count  out  $clog2(NUM_OBS)+1  number of valid slots written
rd_idx  in  $clog2(NUM_OBS)  table read index
rd_valid  out  1  slot rd_idx holds an obstacle
rd_x  out  10  obstacle left edge
rd_y  out  10  obstacle top edge
rd_w  out  6  obstacle width
rd_h  out  6  obstacle height

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE; busy=0, done=0, obs_count=0; all valid bits and table fields 0; slot=0, tries=0.
- States: IDLE, SX, SY, SW, SH, CHK, WR, FIN.
- IDLE:
  - start=1 -> clear all valid bits (fields untouched), obs_count=0, done=0, slot=0, tries=0, busy=1 -> SX.
  - start is ignored in every state other than IDLE.
- SX: rnd<MAP_W -> x=rnd, go SY; else reject.
- SY: rnd<MAP_H -> y=rnd, go SW; else reject.
- SW: w=MIN_SIZE+rnd[4:0], go SH.
- SH: h=MIN_SIZE+rnd[4:0], go CHK.
- CHK: accept iff all of the following hold, else reject:
  - x+w<=MAP_W and y+h<=MAP_H, computed 11 bits wide with no wrap.
  - No overlap with either spawn square. Overlap is strict interval intersection: a.x<b.x+b.w && b.x<a.x+a.w && same on y. Touching edges are not an overlap.
- WR: table[slot]={x,y,w,h}, valid[slot]=1, obs_count++, tries=0. If slot==NUM_OBS-1 go FIN; else slot++ and go SX.
- Reject (from SX, SY or CHK):
  - If tries==MAX_TRIES: slot stays invalid, tries=0, then slot==NUM_OBS-1 ? FIN : (slot++, SX).
  - Else tries++ and go SX.
- FIN: busy=0, done=1, go IDLE. done holds until the next accepted start.
- Obstacles may overlap each other; only map bounds and spawn zones are enforced.
- Latency: best case 6 cycles per slot (SX,SY,SW,SH,CHK,WR). Full accepted run: start cycle, +6*NUM_OBS, +1 FIN, so done rises 50 cycles after start for NUM_OBS=8.
- Read port: purely combinational from the table, valid any time. During busy it reflects partial results.
- Reset mid-run: immediate abort to reset values. No partial table survives.

Decomposition:
- tank_pkg holds:
  - MAP_W/MAP_H defaults
  - obstacle_t struct {x[9:0], y[9:0], w[5:0], h[5:0]}
  - the state enum
  - the rect_overlap function signature
- One natural sub-module: rect_overlap, purely combinational. It takes two obstacle_t and returns 1 if they strictly intersect; instantiated twice, once per spawn zone.
- The table is a flop array, NUM_OBS x 32 bits, plus the valid vector.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle -> busy=0, done=0, obs_count=0, rd_valid=0 for all rd_idx.
- Nominal: start, then drive rnd repeating 100,50,4,8 -> every slot reads x=100,y=50,w=20,h=24, valid=1; done rises 50 cycles after start; obs_count=8.
- Range reject: at SX drive 700, then 100,50,4,8 -> one extra try; slot 0 = (100,50,20,24); the 700 is never stored.
- Bounds edge: sequence 620,300,4,0 -> accepted, since 620+20=640. Sequence 621,300,4,0 -> rejected.
- Keep-out: sequence 40,40,0,0 -> rejected (overlaps spawn 0). Sequence 64,32,0,0 -> accepted (touches edge x=64 only).
- Exhaustion and robustness:
  - Hold rnd=1023 -> each slot skipped after 16 rejects; done=1, obs_count=0.
  - Pulse start while busy -> no effect.
  - Reset_n=0 mid-run -> all valid cleared immediately.
